// File: rtl/onewire_master.sv
// onewire_master: 1-Wire bus master issuing reset/presence, write-byte and read-byte sequences.
// Overdrive timing is built only when ONEWIRE_OD_EN is defined; otherwise all commands use standard timing.
module onewire_master #(
  parameter int CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       od,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       busy,
  input  logic       IO_i,
  output logic       IO_o
);

  localparam int CW = $clog2(480 * CLKS_PER_US + 1);

  typedef enum logic [2:0] {IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    op_q;
  logic [7:0]    shreg;
  logic          w0_q;
  logic          io_meta, io_sync;

  int   t_rstl, t_msp, t_rsth, t_w1, t_w0, t_samp, t_slot;
  int   cnt_i, t_low, t_low_entry;
  logic w0_entry, samp_now;

  // During IDLE the incoming od selects timing so the first phase loads correctly at accept.
`ifdef ONEWIRE_OD_EN
  logic od_q;
  logic od_eff;
  assign od_eff = (state == IDLE) ? od : od_q;

  always_comb begin
    t_rstl = (od_eff ? 48 : 480) * CLKS_PER_US;
    t_msp  = (od_eff ? 8  : 70 ) * CLKS_PER_US;
    t_rsth = (od_eff ? 40 : 410) * CLKS_PER_US;
    t_w1   = (od_eff ? 1  : 6  ) * CLKS_PER_US;
    t_w0   = (od_eff ? 8  : 60 ) * CLKS_PER_US;
    t_samp = (od_eff ? 2  : 15 ) * CLKS_PER_US;
    t_slot = (od_eff ? 10 : 70 ) * CLKS_PER_US;
  end
`else
  logic od_unused;
  assign od_unused = od;

  always_comb begin
    t_rstl = 480 * CLKS_PER_US;
    t_msp  = 70 * CLKS_PER_US;
    t_rsth = 410 * CLKS_PER_US;
    t_w1   = 6 * CLKS_PER_US;
    t_w0   = 60 * CLKS_PER_US;
    t_samp = 15 * CLKS_PER_US;
    t_slot = 70 * CLKS_PER_US;
  end
`endif

  // The counter value equals (slot length - 1 - slot time), so the sample can land in either slot phase.
  always_comb begin
    cnt_i       = int'(cnt);
    w0_entry    = (state == IDLE) ? (cmd_op == 2'b01 && !cmd_data[0])
                                  : (op_q == 2'b01 && !shreg[0]);
    t_low_entry = w0_entry ? t_w0 : t_w1;
    t_low       = w0_q ? t_w0 : t_w1;
    samp_now    = ((state == SLOT_LOW) && (cnt_i == t_low - 1 - t_samp)) ||
                  ((state == SLOT_REL) && (cnt_i == t_slot - t_samp - 1));
  end

  assign busy = ~cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      op_q         <= '0;
      shreg        <= '0;
      w0_q         <= 1'b0;
      io_meta      <= 1'b1;
      io_sync      <= 1'b1;
      IO_o         <= 1'b0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_presence <= 1'b0;
`ifdef ONEWIRE_OD_EN
      od_q         <= 1'b0;
`endif
    end else begin
      io_meta   <= IO_i;
      io_sync   <= io_meta;
      rsp_valid <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (samp_now) shreg <= {io_sync, shreg[7:1]};

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            shreg     <= cmd_data;
            bit_cnt   <= '0;
`ifdef ONEWIRE_OD_EN
            od_q      <= od;
`endif
            case (cmd_op)
              2'b00: begin
                state <= RST_LOW;
                IO_o  <= 1'b1;
                cnt   <= CW'(t_rstl - 1);
              end
              2'b01, 2'b10: begin
                state <= SLOT_LOW;
                IO_o  <= 1'b1;
                w0_q  <= w0_entry;
                cnt   <= CW'(t_low_entry - 1);
              end
              default: state <= DONE;
            endcase
          end
        end
        RST_LOW: begin
          if (cnt == '0) begin
            state <= RST_REL;
            IO_o  <= 1'b0;
            cnt   <= CW'(t_rsth - 1);
          end
        end
        RST_REL: begin
          if (cnt_i == t_rsth - t_msp - 1) rsp_presence <= ~io_sync;
          if (cnt == '0) state <= DONE;
        end
        SLOT_LOW: begin
          if (cnt == '0) begin
            state <= SLOT_REL;
            IO_o  <= 1'b0;
            cnt   <= CW'(t_slot - t_low - 1);
          end
        end
        SLOT_REL: begin
          if (cnt == '0) begin
            if (bit_cnt == 3'd7) begin
              state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              state   <= SLOT_LOW;
              IO_o    <= 1'b1;
              w0_q    <= w0_entry;
              cnt     <= CW'(t_low_entry - 1);
            end
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
          if (op_q == 2'b11) rsp_data <= '0;
          else if (op_q != 2'b00) rsp_data <= shreg;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
